// File: rtl/multicycle_ctrl_v2_if.sv
// Control bundle between the multicycle controller (master) and the MIPS datapath (slave).
// Carries instruction fields, status flags, mux selects, enables and debug state.
interface multicycle_ctrl_v2_if #(
  parameter int OPCODE_W  = 6,
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 3
);
  logic [OPCODE_W-1:0]  opcode;
  logic [FUNCT_W-1:0]   funct;
  logic                 zero;
  logic                 mem_ready;
  logic                 mem_read;
  logic                 mem_write;
  logic                 iord;
  logic                 ir_write;
  logic                 pc_en;
  logic [1:0]           pc_src;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic                 zero_ext;
  logic [ALUCTRL_W-1:0] alu_control;
  logic [1:0]           reg_dst;
  logic [1:0]           mem_to_reg;
  logic                 reg_write;
  logic                 illegal_op;
  logic [3:0]           state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
           zero_ext, alu_control, reg_dst, mem_to_reg, reg_write, illegal_op, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_read, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
           zero_ext, alu_control, reg_dst, mem_to_reg, reg_write, illegal_op, state
  );
endinterface

// File: rtl/multicycle_ctrl_v2.sv
// Multicycle MIPS control FSM: decodes opcode/funct into datapath selects, enables and ALU control.
// Memory states stall on mem_ready (when MEM_WAIT_EN); illegal instructions trap and set a sticky flag.
module multicycle_ctrl_v2 #(
  parameter int OPCODE_W    = 6,
  parameter int FUNCT_W     = 6,
  parameter int ALUCTRL_W   = 3,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_ctrl_v2_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    ALU_WB    = 4'd7,
    BRANCH    = 4'd8,
    IMM_EXEC  = 4'd9,
    IMM_WB    = 4'd10,
    JUMP      = 4'd11,
    JAL       = 4'd12,
    JR        = 4'd13,
    TRAP      = 4'd14
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(6'b000011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(6'b001010);
  localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'b001100);
  localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b001101);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);

  localparam logic [FUNCT_W-1:0] FN_JR  = FUNCT_W'(6'b001000);
  localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] FN_SLT = FUNCT_W'(6'b101010);

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(3'b010);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(3'b110);
  localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(3'b000);
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3'b001);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(3'b111);

  state_t state, next;
  logic   illegal;
  logic   mem_rdy;
  logic   imm_zext;

  assign mem_rdy  = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
  // Logical immediates zero-extend in both the execute and write-back cycles.
  assign imm_zext = (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      illegal <= 1'b0;
    end else begin
      state <= next;
      if (state == TRAP)
        illegal <= 1'b1;
    end
  end

  always_comb begin
    next            = FETCH;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.iord        = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_en       = 1'b0;
    bus.pc_src      = 2'b00;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = 2'b00;
    bus.zero_ext    = 1'b0;
    bus.alu_control = ALU_ADD;
    bus.reg_dst     = 2'b00;
    bus.mem_to_reg  = 2'b00;
    bus.reg_write   = 1'b0;

    case (state)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        if (mem_rdy) begin
          bus.ir_write = 1'b1;
          bus.pc_en    = 1'b1;
          next         = DECODE;
        end else begin
          next = FETCH;
        end
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: next = MEM_ADR;
          OP_RTYPE: begin
            case (bus.funct)
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: next = EXECUTE;
              FN_JR:   next = JR;
              default: next = TRAP;
            endcase
          end
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next = IMM_EXEC;
          OP_BEQ, OP_BNE: next = BRANCH;
          OP_J:    next = JUMP;
          OP_JAL:  next = JAL;
          default: next = TRAP;
        endcase
      end
      MEM_ADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        next = (bus.opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        next = mem_rdy ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        bus.mem_to_reg = 2'b01;
        bus.reg_write  = 1'b1;
      end
      MEM_WRITE: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        next = mem_rdy ? FETCH : MEM_WRITE;
      end
      EXECUTE: begin
        bus.alu_src_a = 1'b1;
        case (bus.funct)
          FN_SUB:  bus.alu_control = ALU_SUB;
          FN_AND:  bus.alu_control = ALU_AND;
          FN_OR:   bus.alu_control = ALU_OR;
          FN_SLT:  bus.alu_control = ALU_SLT;
          default: bus.alu_control = ALU_ADD;
        endcase
        next = ALU_WB;
      end
      ALU_WB: begin
        bus.reg_dst   = 2'b01;
        bus.reg_write = 1'b1;
      end
      IMM_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.zero_ext  = imm_zext;
        case (bus.opcode)
          OP_ANDI: bus.alu_control = ALU_AND;
          OP_ORI:  bus.alu_control = ALU_OR;
          OP_SLTI: bus.alu_control = ALU_SLT;
          default: bus.alu_control = ALU_ADD;
        endcase
        next = IMM_WB;
      end
      IMM_WB: begin
        bus.zero_ext  = imm_zext;
        bus.reg_write = 1'b1;
      end
      BRANCH: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_control = ALU_SUB;
        bus.pc_src      = 2'b01;
        bus.pc_en       = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
      end
      JUMP: begin
        bus.pc_src = 2'b10;
        bus.pc_en  = 1'b1;
      end
      JAL: begin
        // Register file writes the already-incremented PC as the PC loads the target.
        bus.pc_src     = 2'b10;
        bus.pc_en      = 1'b1;
        bus.reg_dst    = 2'b10;
        bus.mem_to_reg = 2'b10;
        bus.reg_write  = 1'b1;
      end
      JR: begin
        bus.pc_src = 2'b11;
        bus.pc_en  = 1'b1;
      end
      TRAP:    next = FETCH;
      default: next = FETCH;
    endcase

    // State already shows FETCH during reset; only the write enables need squashing.
    if (!rst) begin
      bus.ir_write  = 1'b0;
      bus.pc_en     = 1'b0;
      bus.reg_write = 1'b0;
      bus.mem_write = 1'b0;
    end
  end

  assign bus.state      = state;
  assign bus.illegal_op = illegal;

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Directed-vector bench for multicycle_ctrl_v2: walks each instruction class through its states
// and compares selects/enables against hand-derived values.
module tb_multicycle_ctrl_v2;
  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  multicycle_ctrl_v2_if #(.OPCODE_W(6), .FUNCT_W(6), .ALUCTRL_W(3)) bus ();

  multicycle_ctrl_v2 #(
    .OPCODE_W(6), .FUNCT_W(6), .ALUCTRL_W(3), .MEM_WAIT_EN(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are then changed and outputs sampled mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Starts in FETCH (ready): checks the fetch cycle and lands in DECODE.
  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
    bus.mem_ready = 1'b1;
    bus.opcode    = op;
    bus.funct     = fn;
    #1;
    chk("fetch_state", bus.state, 0);
    chk("fetch_irw",   bus.ir_write, 1);
    chk("fetch_pcen",  bus.pc_en, 1);
    cyc();
    chk("decode_state", bus.state, 1);
    chk("decode_srcb",  bus.alu_src_b, 2'b11);
  endtask

  int wr_cycles;

  initial begin
    rst           = 1'b0;
    bus.opcode    = 6'd0;
    bus.funct     = 6'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;

    // Reset: FETCH values shown, write enables squashed despite mem_ready.
    #12;
    chk("rst_state",   bus.state, 0);
    chk("rst_illegal", bus.illegal_op, 0);
    chk("rst_irw",     bus.ir_write, 0);
    chk("rst_pcen",    bus.pc_en, 0);
    chk("rst_memrd",   bus.mem_read, 1);
    chk("rst_srcb",    bus.alu_src_b, 2'b01);
    bus.mem_ready = 1'b0;
    #1 rst = 1'b1;

    // Fetch stall.
    cyc();
    chk("stall_state", bus.state, 0);
    chk("stall_irw",   bus.ir_write, 0);
    chk("stall_memrd", bus.mem_read, 1);

    // lw, zero wait: 0,1,2,3,4,0
    fetch_decode(6'b100011, 6'd0);
    chk("lw_dec_rw", bus.reg_write, 0);
    cyc();
    chk("lw_adr_state", bus.state, 2);
    chk("lw_adr_srca",  bus.alu_src_a, 1);
    chk("lw_adr_srcb",  bus.alu_src_b, 2'b10);
    chk("lw_adr_rw",    bus.reg_write, 0);
    cyc();
    chk("lw_rd_state", bus.state, 3);
    chk("lw_rd_memrd", bus.mem_read, 1);
    chk("lw_rd_iord",  bus.iord, 1);
    chk("lw_rd_rw",    bus.reg_write, 0);
    cyc();
    chk("lw_wb_state", bus.state, 4);
    chk("lw_wb_rw",    bus.reg_write, 1);
    chk("lw_wb_m2r",   bus.mem_to_reg, 2'b01);
    chk("lw_wb_dst",   bus.reg_dst, 2'b00);
    cyc();

    // sw with three wait cycles in MEM_WRITE: 7 cycles total.
    fetch_decode(6'b101011, 6'd0);
    bus.mem_ready = 1'b0;  // ignored outside memory states
    cyc();
    chk("sw_adr_state", bus.state, 2);
    wr_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.mem_ready = (i == 3);
      #1;
      chk("sw_wr_state", bus.state, 5);
      chk("sw_wr_iord",  bus.iord, 1);
      chk("sw_wr_rw",    bus.reg_write, 0);
      if (bus.mem_write) wr_cycles++;
    end
    chk("sw_wr_cycles", wr_cycles, 4);
    cyc();
    chk("sw_done_state", bus.state, 0);

    // beq: pc_en follows zero.
    fetch_decode(6'b000100, 6'd0);
    cyc();
    bus.zero = 1'b1;
    #1;
    chk("beq_state",  bus.state, 8);
    chk("beq_z1_pcen", bus.pc_en, 1);
    chk("beq_pcsrc",  bus.pc_src, 2'b01);
    chk("beq_alu",    bus.alu_control, 3'b110);
    bus.zero = 1'b0;
    #1;
    chk("beq_z0_pcen", bus.pc_en, 0);
    cyc();

    // bne: inverse.
    fetch_decode(6'b000101, 6'd0);
    cyc();
    bus.zero = 1'b1;
    #1;
    chk("bne_z1_pcen", bus.pc_en, 0);
    bus.zero = 1'b0;
    #1;
    chk("bne_z0_pcen", bus.pc_en, 1);
    cyc();
    chk("bne_done_state", bus.state, 0);

    // andi / ori / slti.
    fetch_decode(6'b001100, 6'd0);
    cyc();
    chk("andi_state", bus.state, 9);
    chk("andi_alu",   bus.alu_control, 3'b000);
    chk("andi_zext",  bus.zero_ext, 1);
    cyc();
    chk("andi_wb_state", bus.state, 10);
    chk("andi_wb_zext",  bus.zero_ext, 1);
    chk("andi_wb_rw",    bus.reg_write, 1);
    cyc();
    fetch_decode(6'b001101, 6'd0);
    cyc();
    chk("ori_alu",  bus.alu_control, 3'b001);
    chk("ori_zext", bus.zero_ext, 1);
    cyc();
    cyc();
    fetch_decode(6'b001010, 6'd0);
    cyc();
    chk("slti_alu",  bus.alu_control, 3'b111);
    chk("slti_zext", bus.zero_ext, 0);
    cyc();
    cyc();

    // jal.
    fetch_decode(6'b000011, 6'd0);
    cyc();
    chk("jal_state", bus.state, 12);
    chk("jal_pcen",  bus.pc_en, 1);
    chk("jal_rw",    bus.reg_write, 1);
    chk("jal_dst",   bus.reg_dst, 2'b10);
    chk("jal_m2r",   bus.mem_to_reg, 2'b10);
    chk("jal_pcsrc", bus.pc_src, 2'b10);
    cyc();

    // jr.
    fetch_decode(6'b000000, 6'b001000);
    cyc();
    chk("jr_state", bus.state, 13);
    chk("jr_pcsrc", bus.pc_src, 2'b11);
    chk("jr_pcen",  bus.pc_en, 1);
    cyc();

    // Illegal opcode traps; flag set on leaving TRAP.
    fetch_decode(6'b111111, 6'd0);
    cyc();
    chk("trap_state", bus.state, 14);
    chk("trap_pcen",  bus.pc_en, 0);
    chk("trap_rw",    bus.reg_write, 0);
    chk("trap_flag_before", bus.illegal_op, 0);
    cyc();
    chk("trap_flag_after", bus.illegal_op, 1);

    // add runs normally afterwards.
    fetch_decode(6'b000000, 6'b100000);
    cyc();
    chk("add_state", bus.state, 6);
    chk("add_alu",   bus.alu_control, 3'b010);
    cyc();
    chk("add_wb_state", bus.state, 7);
    chk("add_wb_dst",   bus.reg_dst, 2'b01);
    chk("add_wb_rw",    bus.reg_write, 1);
    chk("add_flag",     bus.illegal_op, 1);
    cyc();

    // sub, reset asserted mid-EXECUTE.
    fetch_decode(6'b000000, 6'b100010);
    cyc();
    chk("sub_alu", bus.alu_control, 3'b110);
    rst = 1'b0;
    #1;
    chk("mid_rst_state", bus.state, 0);
    chk("mid_rst_irw",   bus.ir_write, 0);
    chk("mid_rst_pcen",  bus.pc_en, 0);
    chk("mid_rst_rw",    bus.reg_write, 0);
    chk("mid_rst_flag",  bus.illegal_op, 0);
    cyc();
    chk("held_rst_state", bus.state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
